uart_frame_chk: RTL and testbench

UART_FRAME_CHK -- requirements
Module: uart_frame_chk

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_frame_chk_sat_counter.sv | 19 +
 rtl/uart_frame_chk.sv | 150 +++++++++++++++
 tb/tb_uart_frame_chk.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: frame-checker state encoding and parity sense.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int unsigned PAR_EVEN = 0;
  localparam int unsigned PAR_ODD  = 1;

endpackage

// File: rtl/uart_frame_chk_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_frame_chk.sv
// UART frame checker: assembles sampled bits into a frame, checks start/parity/stop,
// reports per-frame completion pulses, sticky error flags and saturating error counts.
module uart_frame_chk
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PAR_EN     = 1,
  parameter int unsigned PAR_TYPE   = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  sampled_bit,
  input  logic                  sample_done,
  input  logic                  frame_start,
  input  logic                  abort,
  input  logic                  clear_flags,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stop_err,
  output logic [CNT_WIDTH-1:0]  glitch_cnt,
  output logic [CNT_WIDTH-1:0]  par_cnt,
  output logic [CNT_WIDTH-1:0]  stop_cnt
);

  localparam int unsigned     IDX_W     = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic            PAR_SENSE = (PAR_TYPE == PAR_ODD);

  rx_state_e              state, state_nx;
  logic [IDX_W-1:0]       bit_idx;
  logic                   stop_idx;
  logic [DATA_WIDTH-1:0]  data_buf;
  logic                   bad;
  logic                   glitch_hit, par_hit, stop_hit, frame_done;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Every event strobe is derived inside the non-abort branch, so abort masks them all.
  always_comb begin
    state_nx   = state;
    glitch_hit = 1'b0;
    par_hit    = 1'b0;
    stop_hit   = 1'b0;
    frame_done = 1'b0;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (frame_start) state_nx = ST_START;
        ST_START: if (sample_done) begin
          if (sampled_bit) begin
            glitch_hit = 1'b1;
            state_nx   = ST_IDLE;
          end else begin
            state_nx = ST_DATA;
          end
        end
        ST_DATA: if (sample_done && (bit_idx == LAST_IDX))
          state_nx = (PAR_EN != 0) ? ST_PARITY : ST_STOP;
        ST_PARITY: if (sample_done) begin
          par_hit  = (sampled_bit != ((^data_buf) ^ PAR_SENSE));
          state_nx = ST_STOP;
        end
        ST_STOP: if (sample_done) begin
          stop_hit = ~sampled_bit;
          if ((STOP_BITS == 1) || stop_idx) begin
            frame_done = 1'b1;
            state_nx   = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      data_buf    <= '0;
      bad         <= 1'b0;
      data_out    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (sample_done && !abort) begin
        case (state)
          ST_START: begin
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            bad      <= 1'b0;
          end
          ST_DATA: begin
            data_buf[bit_idx] <= sampled_bit;
            bit_idx           <= bit_idx + 1'b1;
          end
          ST_PARITY: if (par_hit) bad <= 1'b1;
          ST_STOP: begin
            stop_idx <= 1'b1;
            if (stop_hit) bad <= 1'b1;
            if (frame_done) begin
              frame_valid <= !(bad || stop_hit);
              frame_err   <= bad || stop_hit;
              if (!(bad || stop_hit)) data_out <= data_buf;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stop_err    <= 1'b0;
    end else begin
      if (glitch_hit)       strt_glitch <= 1'b1;
      else if (clear_flags) strt_glitch <= 1'b0;
      if (par_hit)          par_err     <= 1'b1;
      else if (clear_flags) par_err     <= 1'b0;
      if (stop_hit)         stop_err    <= 1'b1;
      else if (clear_flags) stop_err    <= 1'b0;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_glitch_cnt (
    .CLK(CLK), .RST(RST), .inc(glitch_hit), .count(glitch_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_par_cnt (
    .CLK(CLK), .RST(RST), .inc(par_hit), .count(par_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stop_cnt (
    .CLK(CLK), .RST(RST), .inc(stop_hit), .count(stop_cnt)
  );

endmodule

// File: tb/tb_uart_frame_chk.sv
// Bench for uart_frame_chk: frame-level expectation model checked every cycle,
// plus literal spot checks, on an 8-bit even-parity, 2-stop, 2-bit-counter build.
module tb_uart_frame_chk;

  localparam int unsigned PTYPE = 0;
  localparam int          CMAX  = 3;

  logic       clk = 1'b0;
  logic       rst, sbit, sdone, fstart, abrt, clr;
  logic [7:0] data_out;
  logic       frame_valid, frame_err, strt_glitch, par_err, stop_err;
  logic [1:0] glitch_cnt, par_cnt, stop_cnt;

  logic [7:0] exp_data;
  bit         exp_valid, exp_err, exp_glitch, exp_par, exp_stop;
  int         exp_gcnt, exp_pcnt, exp_scnt;
  bit         check_en = 1'b0;
  int         checks   = 0;
  int         passes   = 0;

  uart_frame_chk #(
    .DATA_WIDTH(8), .PAR_EN(1), .PAR_TYPE(PTYPE), .STOP_BITS(2), .CNT_WIDTH(2)
  ) dut (
    .CLK(clk), .RST(rst), .sampled_bit(sbit), .sample_done(sdone),
    .frame_start(fstart), .abort(abrt), .clear_flags(clr),
    .data_out(data_out), .frame_valid(frame_valid), .frame_err(frame_err),
    .strt_glitch(strt_glitch), .par_err(par_err), .stop_err(stop_err),
    .glitch_cnt(glitch_cnt), .par_cnt(par_cnt), .stop_cnt(stop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("data_out",    {24'b0, data_out},    {24'b0, exp_data});
      chk("frame_valid", {31'b0, frame_valid}, {31'b0, exp_valid});
      chk("frame_err",   {31'b0, frame_err},   {31'b0, exp_err});
      chk("strt_glitch", {31'b0, strt_glitch}, {31'b0, exp_glitch});
      chk("par_err",     {31'b0, par_err},     {31'b0, exp_par});
      chk("stop_err",    {31'b0, stop_err},    {31'b0, exp_stop});
      chk("glitch_cnt",  {30'b0, glitch_cnt},  exp_gcnt);
      chk("par_cnt",     {30'b0, par_cnt},     exp_pcnt);
      chk("stop_cnt",    {30'b0, stop_cnt},    exp_scnt);
    end
  end

  function automatic int sat(input int c);
    return (c < CMAX) ? c + 1 : c;
  endfunction

  // One clock: inputs held across one rising edge, model updated just after it.
  task automatic step(input bit sd, input bit b, input bit fs, input bit ab,
                      input bit cl, input bit rs);
    sdone = sd; sbit = b; fstart = fs; abrt = ab; clr = cl; rst = rs;
    @(posedge clk); #1;
    sdone = 0; sbit = 0; fstart = 0; abrt = 0; clr = 0; rst = 0;
    exp_valid = 0; exp_err = 0;
  endtask

  task automatic idle();             step(0, 0, 0, 0, 0, 0); endtask
  task automatic sample(input bit b); step(1, b, 0, 0, 0, 0); endtask

  task automatic reset_model();
    exp_data = '0; exp_valid = 0; exp_err = 0;
    exp_glitch = 0; exp_par = 0; exp_stop = 0;
    exp_gcnt = 0; exp_pcnt = 0; exp_scnt = 0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit p, input bit s0,
                            input bit s1, input bit gaps);
    bit bad = 0;
    step(0, 0, 1, 0, 0, 0);
    sample(0);
    for (int i = 0; i < 8; i++) begin
      sample(d[i]);
      if (i == 3) step(0, 0, 1, 0, 0, 0);
      if (gaps) idle();
    end
    sample(p);
    if (p != ((($countones(d) % 2) == 1) ^ (PTYPE == 1))) begin
      exp_par = 1; exp_pcnt = sat(exp_pcnt); bad = 1;
    end
    sample(s0);
    if (!s0) begin exp_stop = 1; exp_scnt = sat(exp_scnt); bad = 1; end
    sample(s1);
    if (!s1) begin exp_stop = 1; exp_scnt = sat(exp_scnt); bad = 1; end
    if (bad) exp_err = 1;
    else begin exp_valid = 1; exp_data = d; end
    idle();
  endtask

  task automatic glitch(input bit cl);
    step(0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, cl, 0);
    if (cl) begin exp_par = 0; exp_stop = 0; end
    exp_glitch = 1; exp_gcnt = sat(exp_gcnt);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    sdone = 0; sbit = 0; fstart = 0; abrt = 0; clr = 0; rst = 1;
    reset_model();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check_en = 1;
    idle();
    chk("lit_reset_data", {24'b0, data_out}, 32'h0);

    send_frame(8'hA5, 0, 1, 1, 1);
    chk("lit_good_a5", {24'b0, data_out}, 32'hA5);
    send_frame(8'h3C, 0, 1, 1, 0);

    send_frame(8'h01, 0, 1, 1, 1);
    chk("lit_par_cnt", {30'b0, par_cnt}, 32'd1);
    chk("lit_data_hold", {24'b0, data_out}, 32'h3C);
    send_frame(8'h07, 1, 1, 1, 0);

    step(0, 0, 0, 0, 1, 0);
    exp_glitch = 0; exp_par = 0; exp_stop = 0;
    idle();

    send_frame(8'h5A, 0, 1, 0, 1);
    chk("lit_stop_cnt", {30'b0, stop_cnt}, 32'd1);
    send_frame(8'h80, 0, 0, 0, 0);
    chk("lit_stop_sat", {30'b0, stop_cnt}, 32'd3);

    glitch(0);
    glitch(1);
    chk("lit_glitch_vs_clr", {31'b0, strt_glitch}, 32'd1);
    glitch(0); glitch(0); glitch(0);
    chk("lit_glitch_sat", {30'b0, glitch_cnt}, 32'd3);

    // Abort while bit 4 is being sampled; trailing strobes must be ignored in IDLE.
    step(0, 0, 1, 0, 0, 0);
    sample(0);
    for (int i = 0; i < 4; i++) sample(1);
    step(1, 1, 0, 1, 0, 0);
    sample(1); sample(1); sample(0);
    send_frame(8'h96, 0, 1, 1, 0);
    chk("lit_after_abort", {24'b0, data_out}, 32'h96);

    // Abort coinciding with the final stop sample suppresses completion.
    step(0, 0, 1, 0, 0, 0);
    sample(0);
    for (int i = 0; i < 8; i++) sample(i == 0 || i == 4);
    sample(0);
    sample(1);
    step(1, 1, 0, 1, 0, 0);
    idle();

    step(0, 0, 1, 0, 0, 0);
    sample(0);
    sample(1); sample(0); sample(1);
    step(0, 0, 0, 0, 0, 1);
    reset_model();
    chk("lit_rst_glitch_cnt", {30'b0, glitch_cnt}, 32'd0);
    idle();
    send_frame(8'hC3, 0, 1, 1, 1);
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
